ddr3_cmd_arbiter: RTL and testbench
===================================

Name: ddr3_cmd_arbiter

Overview:
- Sits directly downstream of the AXI-to-memory request front-end.
- Consumes its separate write-request and read-request ports and arbitrates between them, with read priority and a write-starvation bound.
- Holds the grant across multi-request sequences, decodes byte addresses into bank/row/column, and issues one registered command stream to the DDR3 command FSM.

Parameters:
- ADDRS, 32, byte-address width.
- WIDTH, 32, datapath width in bits; byte-offset bits BBITS = log2(WIDTH/8) are dropped from addresses.
- MEM_ID_WIDTH, 4, transaction-ID width.
- COL_BITS, 10, DDR3 column bits.
- ROW_BITS, 13, DDR3 row bits.
- BANK_BITS, 3, DDR3 bank bits.
- WR_MAX_WAIT, 8, cycles a pending write may be bypassed by reads before it is forced; must be at least 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_wrreq_i  in  1  write request valid
- mem_wrack_o  out  1  write request accepted (one-cycle pulse)
- mem_wrerr_o  out  1  write request rejected, out of range; pulses with ack
- mem_wrlst_i  in  1  last request of a write sequence
- mem_wrtid_i  in  MEM_ID_WIDTH  write transaction ID
- mem_wradr_i  in  ADDRS  write byte address
- mem_rdreq_i, mem_rdack_o, mem_rderr_o, mem_rdlst_i, mem_rdtid_i, mem_rdadr_i  same as write-side equivalents, for reads
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  FSM accepts command
- cmd_write_o  out  1  1 = write, 0 = read
- cmd_last_o  out  1  last command of a sequence
- cmd_tid_o  out  MEM_ID_WIDTH  transaction ID
- cmd_bank_o  out  BANK_BITS  bank
- cmd_row_o  out  ROW_BITS  row
- cmd_col_o  out  COL_BITS  column
- cmd_hit_o  out  1  page-hit hint (optional feature)

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, wr_wait = 0.
- Address map, with word address w = adr >> BBITS:
  - col = w[COL_BITS-1:0]
  - bank = w[COL_BITS +: BANK_BITS]
  - row = w[COL_BITS+BANK_BITS +: ROW_BITS]
  - If any address bit at or above BBITS+COL_BITS+BANK_BITS+ROW_BITS is set, the request is out of range.
- Output register is a single entry. It may load when it is empty, or when cmd_valid_o & cmd_ready_i in the same cycle; full throughput is 1 command/cycle.
- Ack rules:
  - ack/err are combinational from the grant and load-enable.
  - At most one of mem_wrack_o / mem_rdack_o is high per cycle.
  - Out-of-range: ack=1, err=1, no command loaded, sequence lock unchanged.
- FSM state IDLE:
  - Grant read if mem_rdreq_i and wr_wait < WR_MAX_WAIT; otherwise grant write if mem_wrreq_i; otherwise grant read if mem_rdreq_i.
  - A granted request with lst=0 moves to LOCK_WR or LOCK_RD accordingly.
- FSM states LOCK_WR / LOCK_RD:
  - Only the locked direction is granted; the other side's req is ignored (no ack).
  - Return to IDLE on the accepted request with lst=1.
- wr_wait:
  - Increments (saturating at WR_MAX_WAIT) on each cycle mem_wrreq_i is high and not acked.
  - Clears on a write ack.
  - Is 0 whenever mem_wrreq_i is low.
- Stall: cmd_valid_o held high with stable payload until cmd_ready_i. While the register is full and not draining, no acks are issued.
- Simultaneous requests in IDLE with wr_wait < WR_MAX_WAIT: read wins. At wr_wait == WR_MAX_WAIT: write wins.
- Reset mid-sequence: the lock is dropped, and any pending command is discarded without a handshake.

Optional Feature:
- DDR3_ARB_PAGE_HINT_EN defined:
  - Per-bank open-row table: 2^BANK_BITS entries of ROW_BITS, plus a valid bit each, all cleared on reset.
  - cmd_hit_o = 1 when the loaded command's bank is valid and its stored row equals cmd_row_o.
  - The table updates on each command load.
- Not defined: cmd_hit_o tied to 0; no table is built.

Decomposition:
- Shared package ddr3_cmd_pkg:
  - Command-field widths (COL/ROW/BANK defaults).
  - FSM state encodings: IDLE=0, LOCK_WR=1, LOCK_RD=2.
  - The command struct/bit layout {write, last, tid, bank, row, col}.
- One natural sub-module, ddr3_addr_decode: combinational address split plus range check, instantiated once per request port.

Test Plan:
1. Read 0x0000_1040 (tid 3, lst=1) and write at the same cycle, WR_MAX_WAIT=8 -> rdack first; cmd_write=0, col=0x010, bank=1, row=0; write acked the next cycle.
2. Reads held continuously while a write is pending -> the write is acked exactly after 8 read acks; wr_wait returns to 0.
3. Write sequence of 4 requests (lst=0,0,0,1) while reads are pending -> 4 consecutive write commands with cmd_last only on the 4th; the first read is acked the cycle after.
4. cmd_ready_i held low 5 cycles with a command loaded -> cmd_valid_o and payload stable, no acks; drains and the next request loads the same cycle ready rises.
5. Write to 0x8000_0000, with bit 31 beyond the 28 mapped bits -> wrack=1, wrerr=1, cmd_valid_o stays 0.
6. With DDR3_ARB_PAGE_HINT_EN: two reads to bank 2, row 5, then one to row 6 -> cmd_hit = 0, 1, 0. Also assert reset during a LOCK_RD sequence -> cmd_valid_o=0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/ddr3_cmd_pkg.sv
// Shared definitions for the DDR3 command arbiter: default command-field
// widths, arbiter FSM encodings and the command word layout.
package ddr3_cmd_pkg;

  localparam int COL_BITS_DEF  = 10;
  localparam int ROW_BITS_DEF  = 13;
  localparam int BANK_BITS_DEF = 3;
  localparam int TID_BITS_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK_WR = 2'd1,
    ST_LOCK_RD = 2'd2
  } arb_state_e;

  // Command word layout, MSB first: {write, last, tid, bank, row, col}
  typedef struct packed {
    logic                     write;
    logic                     last;
    logic [TID_BITS_DEF-1:0]  tid;
    logic [BANK_BITS_DEF-1:0] bank;
    logic [ROW_BITS_DEF-1:0]  row;
    logic [COL_BITS_DEF-1:0]  col;
  } cmd_t;

  // Width of a packed command word for arbitrary field widths
  function automatic int cmd_width(input int tid_w, input int bank_w,
                                   input int row_w, input int col_w);
    return 2 + tid_w + bank_w + row_w + col_w;
  endfunction

endpackage

// File: rtl/ddr3_cmd_arbiter_if.sv
// Request and command buses of the DDR3 command arbiter.
// Handshakes: a request (wrreq/rdreq) is consumed in the cycle its ack is
// high, the requester holds req and payload until then. A command transfers
// in the cycle cmd_valid_o & cmd_ready_i; payload is stable while valid waits.
interface ddr3_cmd_arbiter_if
  import ddr3_cmd_pkg::*;
#(
  parameter int ADDRS        = 32,
  parameter int MEM_ID_WIDTH = TID_BITS_DEF,
  parameter int COL_BITS     = COL_BITS_DEF,
  parameter int ROW_BITS     = ROW_BITS_DEF,
  parameter int BANK_BITS    = BANK_BITS_DEF
);
  logic                    mem_wrreq_i;
  logic                    mem_wrack_o;
  logic                    mem_wrerr_o;
  logic                    mem_wrlst_i;
  logic [MEM_ID_WIDTH-1:0] mem_wrtid_i;
  logic [ADDRS-1:0]        mem_wradr_i;
  logic                    mem_rdreq_i;
  logic                    mem_rdack_o;
  logic                    mem_rderr_o;
  logic                    mem_rdlst_i;
  logic [MEM_ID_WIDTH-1:0] mem_rdtid_i;
  logic [ADDRS-1:0]        mem_rdadr_i;
  logic                    cmd_valid_o;
  logic                    cmd_ready_i;
  logic                    cmd_write_o;
  logic                    cmd_last_o;
  logic [MEM_ID_WIDTH-1:0] cmd_tid_o;
  logic [BANK_BITS-1:0]    cmd_bank_o;
  logic [ROW_BITS-1:0]     cmd_row_o;
  logic [COL_BITS-1:0]     cmd_col_o;
  logic                    cmd_hit_o;

  // Arbiter side
  modport slave (
    input  mem_wrreq_i, mem_wrlst_i, mem_wrtid_i, mem_wradr_i,
    input  mem_rdreq_i, mem_rdlst_i, mem_rdtid_i, mem_rdadr_i,
    output mem_wrack_o, mem_wrerr_o, mem_rdack_o, mem_rderr_o,
    output cmd_valid_o, cmd_write_o, cmd_last_o, cmd_tid_o,
    output cmd_bank_o, cmd_row_o, cmd_col_o, cmd_hit_o,
    input  cmd_ready_i
  );

  // Front-end / command FSM side
  modport master (
    output mem_wrreq_i, mem_wrlst_i, mem_wrtid_i, mem_wradr_i,
    output mem_rdreq_i, mem_rdlst_i, mem_rdtid_i, mem_rdadr_i,
    input  mem_wrack_o, mem_wrerr_o, mem_rdack_o, mem_rderr_o,
    input  cmd_valid_o, cmd_write_o, cmd_last_o, cmd_tid_o,
    input  cmd_bank_o, cmd_row_o, cmd_col_o, cmd_hit_o,
    output cmd_ready_i
  );
endinterface

// File: rtl/ddr3_addr_decode.sv
// Splits a byte address into DDR3 column/bank/row and flags addresses that
// have bits set above the mapped range.
module ddr3_addr_decode #(
  parameter int ADDRS     = 32,
  parameter int BBITS     = 2,
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 13,
  parameter int BANK_BITS = 3
) (
  input  logic [ADDRS-1:0]     adr_i,
  output logic [COL_BITS-1:0]  col_o,
  output logic [BANK_BITS-1:0] bank_o,
  output logic [ROW_BITS-1:0]  row_o,
  output logic                 oor_o
);
  localparam int MAP_BITS = BBITS + COL_BITS + BANK_BITS + ROW_BITS;

  assign col_o  = adr_i[BBITS +: COL_BITS];
  assign bank_o = adr_i[BBITS+COL_BITS +: BANK_BITS];
  assign row_o  = adr_i[BBITS+COL_BITS+BANK_BITS +: ROW_BITS];

  generate
    if (ADDRS > MAP_BITS) begin : g_range
      assign oor_o = |adr_i[ADDRS-1:MAP_BITS];
    end else begin : g_norange
      assign oor_o = 1'b0;
    end
    // Byte-offset bits do not reach the DRAM address
    if (BBITS > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^adr_i[BBITS-1:0];
    end
  endgenerate
endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Read/write request arbiter feeding the DDR3 command FSM. Reads have
// priority until a pending write has been bypassed WR_MAX_WAIT times; a
// multi-request sequence (lst=0) locks the grant to its direction.
// Optional feature: DDR3_ARB_PAGE_HINT_EN builds a per-bank open-row table
// driving cmd_hit_o; without it cmd_hit_o is 0.
module ddr3_cmd_arbiter
  import ddr3_cmd_pkg::*;
#(
  parameter int ADDRS        = 32,
  parameter int WIDTH        = 32,
  parameter int MEM_ID_WIDTH = TID_BITS_DEF,
  parameter int COL_BITS     = COL_BITS_DEF,
  parameter int ROW_BITS     = ROW_BITS_DEF,
  parameter int BANK_BITS    = BANK_BITS_DEF,
  parameter int WR_MAX_WAIT  = 8,
  localparam int WW          = $clog2(WR_MAX_WAIT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  ddr3_cmd_arbiter_if.slave    bus,
  output arb_state_e           dbg_state_o,
  output logic [WW-1:0]        dbg_wr_wait_o
);
  localparam int BBITS = $clog2(WIDTH / 8);
  localparam int CMD_W = cmd_width(MEM_ID_WIDTH, BANK_BITS, ROW_BITS, COL_BITS);

  logic [COL_BITS-1:0]  wr_col, rd_col;
  logic [BANK_BITS-1:0] wr_bank, rd_bank;
  logic [ROW_BITS-1:0]  wr_row, rd_row;
  logic                 wr_oor, rd_oor;

  arb_state_e    state_q;
  logic [WW-1:0] wr_wait_q, wr_wait_d;
  logic          valid_q;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic          grant_wr, grant_rd, load_en;
  logic          wr_ack, rd_ack, ld, acc_lst;

  ddr3_addr_decode #(
    .ADDRS(ADDRS), .BBITS(BBITS), .COL_BITS(COL_BITS),
    .ROW_BITS(ROW_BITS), .BANK_BITS(BANK_BITS)
  ) u_wr_dec (
    .adr_i(bus.mem_wradr_i), .col_o(wr_col), .bank_o(wr_bank),
    .row_o(wr_row), .oor_o(wr_oor)
  );

  ddr3_addr_decode #(
    .ADDRS(ADDRS), .BBITS(BBITS), .COL_BITS(COL_BITS),
    .ROW_BITS(ROW_BITS), .BANK_BITS(BANK_BITS)
  ) u_rd_dec (
    .adr_i(bus.mem_rdadr_i), .col_o(rd_col), .bank_o(rd_bank),
    .row_o(rd_row), .oor_o(rd_oor)
  );

  // Pick the direction to serve this cycle
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state_q)
      ST_LOCK_WR: grant_wr = bus.mem_wrreq_i;
      ST_LOCK_RD: grant_rd = bus.mem_rdreq_i;
      default: begin
        if (bus.mem_rdreq_i && (wr_wait_q < WW'(WR_MAX_WAIT))) grant_rd = 1'b1;
        else if (bus.mem_wrreq_i)                               grant_wr = 1'b1;
        else                                                    grant_rd = bus.mem_rdreq_i;
      end
    endcase
  end

  // The output slot can take a new command when empty or draining now
  assign load_en = !valid_q || bus.cmd_ready_i;
  assign wr_ack  = grant_wr && load_en;
  assign rd_ack  = grant_rd && load_en;
  assign ld      = (wr_ack && !wr_oor) || (rd_ack && !rd_oor);
  assign acc_lst = grant_wr ? bus.mem_wrlst_i : bus.mem_rdlst_i;
  assign cmd_d   = grant_wr ? {1'b1, bus.mem_wrlst_i, bus.mem_wrtid_i, wr_bank, wr_row, wr_col}
                            : {1'b0, bus.mem_rdlst_i, bus.mem_rdtid_i, rd_bank, rd_row, rd_col};

  assign bus.mem_wrack_o = wr_ack;
  assign bus.mem_wrerr_o = wr_ack && wr_oor;
  assign bus.mem_rdack_o = rd_ack;
  assign bus.mem_rderr_o = rd_ack && rd_oor;

  // Count how long a pending write has been bypassed, saturating
  always_comb begin
    wr_wait_d = wr_wait_q;
    if (!bus.mem_wrreq_i || wr_ack)         wr_wait_d = '0;
    else if (wr_wait_q < WW'(WR_MAX_WAIT))  wr_wait_d = wr_wait_q + 1'b1;
  end

  // Sequence lock FSM: only accepted (in-range) requests move it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ld && !acc_lst) state_q <= grant_wr ? ST_LOCK_WR : ST_LOCK_RD;
        ST_LOCK_WR, ST_LOCK_RD: if (ld && acc_lst) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-starvation counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_wait_q <= '0;
    else       wr_wait_q <= wr_wait_d;
  end

  // Single-entry command register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else if (ld) begin
      valid_q <= 1'b1;
      cmd_q   <= cmd_d;
    end else if (bus.cmd_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.cmd_valid_o = valid_q;
  assign {bus.cmd_write_o, bus.cmd_last_o, bus.cmd_tid_o,
          bus.cmd_bank_o, bus.cmd_row_o, bus.cmd_col_o} = cmd_q;

`ifdef DDR3_ARB_PAGE_HINT_EN
  logic [BANK_BITS-1:0]  ld_bank;
  logic [ROW_BITS-1:0]   ld_row;
  logic [ROW_BITS-1:0]   open_row_q [2**BANK_BITS];
  logic [2**BANK_BITS-1:0] open_vld_q;
  logic                  hit_q;

  assign ld_row  = cmd_d[COL_BITS +: ROW_BITS];
  assign ld_bank = cmd_d[COL_BITS+ROW_BITS +: BANK_BITS];

  // Open-row table: compare against the old entry, then record the new row
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      open_vld_q <= '0;
      hit_q      <= 1'b0;
      for (int b = 0; b < 2**BANK_BITS; b++) open_row_q[b] <= '0;
    end else if (ld) begin
      hit_q               <= open_vld_q[ld_bank] && (open_row_q[ld_bank] == ld_row);
      open_vld_q[ld_bank] <= 1'b1;
      open_row_q[ld_bank] <= ld_row;
    end
  end

  assign bus.cmd_hit_o = hit_q;
`else
  assign bus.cmd_hit_o = 1'b0;
`endif

  assign dbg_state_o   = state_q;
  assign dbg_wr_wait_o = wr_wait_q;
endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed bench for ddr3_cmd_arbiter (default parameters, WR_MAX_WAIT=8).
module tb_ddr3_cmd_arbiter;
  import ddr3_cmd_pkg::*;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ddr3_cmd_arbiter_if bus ();
  arb_state_e dbg_state;
  logic [3:0] dbg_wr_wait;

  ddr3_cmd_arbiter dut (
    .clock(clock), .reset(reset), .bus(bus),
    .dbg_state_o(dbg_state), .dbg_wr_wait_o(dbg_wr_wait)
  );

  int checks = 0;
  int errors = 0;

  // {write, last, tid, bank, row, col}
  logic [31:0] cmd_obs;
  assign cmd_obs = {bus.cmd_write_o, bus.cmd_last_o, bus.cmd_tid_o,
                    bus.cmd_bank_o, bus.cmd_row_o, bus.cmd_col_o};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_wrreq_i = 1'b0; bus.mem_wrlst_i = 1'b0;
    bus.mem_wrtid_i = '0;   bus.mem_wradr_i = '0;
    bus.mem_rdreq_i = 1'b0; bus.mem_rdlst_i = 1'b0;
    bus.mem_rdtid_i = '0;   bus.mem_rdadr_i = '0;
    bus.cmd_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if ({bus.cmd_valid_o, bus.mem_wrack_o, bus.mem_rdack_o, bus.mem_wrerr_o,
         bus.mem_rderr_o, bus.cmd_hit_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
        {bus.cmd_valid_o, bus.mem_wrack_o, bus.mem_rdack_o, bus.mem_wrerr_o,
         bus.mem_rderr_o, bus.cmd_hit_o});
    end
    checks++;
    if (cmd_obs !== 32'h0) begin
      errors++; $display("FAIL reset_payload got %h exp 0", cmd_obs);
    end
    checks++;
    if (dbg_state !== ST_IDLE || dbg_wr_wait !== 4'd0) begin
      errors++; $display("FAIL reset_state got st=%0d ww=%0d exp st=0 ww=0", dbg_state, dbg_wr_wait);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_priority();
    bus.mem_rdreq_i = 1'b1; bus.mem_rdadr_i = 32'h0000_1040; bus.mem_rdtid_i = 4'd3; bus.mem_rdlst_i = 1'b1;
    bus.mem_wrreq_i = 1'b1; bus.mem_wradr_i = 32'h0000_2000; bus.mem_wrtid_i = 4'd5; bus.mem_wrlst_i = 1'b1;
    #3;
    checks++;
    if ({bus.mem_wrack_o, bus.mem_rdack_o} !== 2'b01) begin
      errors++; $display("FAIL prio_first_ack got wr/rd=%b exp 01", {bus.mem_wrack_o, bus.mem_rdack_o});
    end
    tick();
    bus.mem_rdreq_i = 1'b0;
    checks++;
    if (bus.cmd_valid_o !== 1'b1 || cmd_obs !== {1'b0, 1'b1, 4'd3, 3'd1, 13'd0, 10'h010}) begin
      errors++; $display("FAIL prio_rd_cmd got v=%b %h exp v=1 %h", bus.cmd_valid_o, cmd_obs,
        {1'b0, 1'b1, 4'd3, 3'd1, 13'd0, 10'h010});
    end
    checks++;
    if (dbg_wr_wait !== 4'd1) begin
      errors++; $display("FAIL prio_wr_wait got %0d exp 1", dbg_wr_wait);
    end
    #3;
    checks++;
    if ({bus.mem_wrack_o, bus.mem_rdack_o, bus.mem_wrerr_o} !== 3'b100) begin
      errors++; $display("FAIL prio_second_ack got wr/rd/err=%b exp 100",
        {bus.mem_wrack_o, bus.mem_rdack_o, bus.mem_wrerr_o});
    end
    tick();
    bus.mem_wrreq_i = 1'b0;
    checks++;
    if (cmd_obs !== {1'b1, 1'b1, 4'd5, 3'd2, 13'd0, 10'h000} || dbg_wr_wait !== 4'd0) begin
      errors++; $display("FAIL prio_wr_cmd got %h ww=%0d exp %h ww=0", cmd_obs, dbg_wr_wait,
        {1'b1, 1'b1, 4'd5, 3'd2, 13'd0, 10'h000});
    end
  endtask

  task automatic test_starvation();
    int rd_acks = 0;
    int wr_at = -1;
    int both = 0;
    bus.mem_wrreq_i = 1'b1; bus.mem_wradr_i = 32'h0000_0300; bus.mem_wrtid_i = 4'd9; bus.mem_wrlst_i = 1'b1;
    bus.mem_rdreq_i = 1'b1; bus.mem_rdtid_i = 4'd1; bus.mem_rdlst_i = 1'b1;
    for (int c = 0; c < 20 && wr_at < 0; c++) begin
      bus.mem_rdadr_i = 32'(c * 4);
      #3;
      if (bus.mem_wrack_o && bus.mem_rdack_o) both++;
      if (bus.mem_rdack_o) rd_acks++;
      if (bus.mem_wrack_o) wr_at = c;
      tick();
    end
    bus.mem_wrreq_i = 1'b0;
    bus.mem_rdreq_i = 1'b0;
    checks++;
    if (rd_acks !== 8 || wr_at !== 8) begin
      errors++; $display("FAIL starve_count got rd_acks=%0d wr_cycle=%0d exp 8/8", rd_acks, wr_at);
    end
    checks++;
    if (both !== 0) begin
      errors++; $display("FAIL starve_dual_ack got %0d exp 0", both);
    end
    checks++;
    if (dbg_wr_wait !== 4'd0 || cmd_obs !== {1'b1, 1'b1, 4'd9, 3'd0, 13'd0, 10'h0C0}) begin
      errors++; $display("FAIL starve_wr_cmd got ww=%0d %h exp ww=0 %h", dbg_wr_wait, cmd_obs,
        {1'b1, 1'b1, 4'd9, 3'd0, 13'd0, 10'h0C0});
    end
    tick();
  endtask

  task automatic test_write_seq();
    bus.mem_wrreq_i = 1'b1; bus.mem_wrtid_i = 4'hA;
    bus.mem_rdtid_i = 4'd2; bus.mem_rdlst_i = 1'b1; bus.mem_rdadr_i = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      bus.mem_wradr_i = 32'h0000_4000 + 32'(i * 4);
      bus.mem_wrlst_i = (i == 3);
      if (i >= 1) bus.mem_rdreq_i = 1'b1;
      #3;
      checks++;
      if ({bus.mem_wrack_o, bus.mem_rdack_o} !== 2'b10) begin
        errors++; $display("FAIL wseq_ack%0d got wr/rd=%b exp 10", i, {bus.mem_wrack_o, bus.mem_rdack_o});
      end
      tick();
      checks++;
      if (cmd_obs !== {1'b1, (i == 3), 4'hA, 3'd4, 13'd0, 10'(i)}) begin
        errors++; $display("FAIL wseq_cmd%0d got %h exp %h", i, cmd_obs, {1'b1, (i == 3), 4'hA, 3'd4, 13'd0, 10'(i)});
      end
      if (i == 0) begin
        checks++;
        if (dbg_state !== ST_LOCK_WR) begin
          errors++; $display("FAIL wseq_lock got st=%0d exp 1", dbg_state);
        end
      end
    end
    bus.mem_wrreq_i = 1'b0;
    #3;
    checks++;
    if ({bus.mem_wrack_o, bus.mem_rdack_o} !== 2'b01) begin
      errors++; $display("FAIL wseq_rd_after got wr/rd=%b exp 01", {bus.mem_wrack_o, bus.mem_rdack_o});
    end
    tick();
    bus.mem_rdreq_i = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || bus.cmd_write_o !== 1'b0) begin
      errors++; $display("FAIL wseq_end got st=%0d wr=%b exp st=0 wr=0", dbg_state, bus.cmd_write_o);
    end
  endtask

  task automatic test_stall();
    bus.cmd_ready_i = 1'b1;
    tick(); tick();
    bus.cmd_ready_i = 1'b0;
    bus.mem_rdreq_i = 1'b1; bus.mem_rdadr_i = 32'h0000_0104; bus.mem_rdtid_i = 4'd7; bus.mem_rdlst_i = 1'b1;
    #3;
    checks++;
    if (bus.mem_rdack_o !== 1'b1) begin
      errors++; $display("FAIL stall_load got rdack=%b exp 1", bus.mem_rdack_o);
    end
    tick();
    bus.mem_rdadr_i = 32'h0100_0008; bus.mem_rdtid_i = 4'd8;
    for (int c = 0; c < 5; c++) begin
      #3;
      checks++;
      if ({bus.cmd_valid_o, bus.mem_rdack_o, bus.mem_wrack_o} !== 3'b100) begin
        errors++; $display("FAIL stall_hold%0d got v/rd/wr=%b exp 100", c,
          {bus.cmd_valid_o, bus.mem_rdack_o, bus.mem_wrack_o});
      end
      checks++;
      if (cmd_obs !== {1'b0, 1'b1, 4'd7, 3'd0, 13'd0, 10'h041}) begin
        errors++; $display("FAIL stall_payload%0d got %h exp %h", c, cmd_obs, {1'b0, 1'b1, 4'd7, 3'd0, 13'd0, 10'h041});
      end
      tick();
    end
    bus.cmd_ready_i = 1'b1;
    #3;
    checks++;
    if (bus.mem_rdack_o !== 1'b1) begin
      errors++; $display("FAIL stall_drain_ack got rdack=%b exp 1", bus.mem_rdack_o);
    end
    tick();
    bus.mem_rdreq_i = 1'b0;
    checks++;
    if (bus.cmd_valid_o !== 1'b1 || cmd_obs !== {1'b0, 1'b1, 4'd8, 3'd0, 13'd512, 10'd2}) begin
      errors++; $display("FAIL stall_next got v=%b %h exp v=1 %h", bus.cmd_valid_o, cmd_obs,
        {1'b0, 1'b1, 4'd8, 3'd0, 13'd512, 10'd2});
    end
    tick();
    checks++;
    if (bus.cmd_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_empty got v=%b exp 0", bus.cmd_valid_o);
    end
  endtask

  task automatic test_out_of_range();
    bus.mem_wrreq_i = 1'b1; bus.mem_wradr_i = 32'h8000_0000; bus.mem_wrtid_i = 4'd2; bus.mem_wrlst_i = 1'b0;
    #3;
    checks++;
    if ({bus.mem_wrack_o, bus.mem_wrerr_o} !== 2'b11) begin
      errors++; $display("FAIL oor_ack got ack/err=%b exp 11", {bus.mem_wrack_o, bus.mem_wrerr_o});
    end
    tick();
    bus.mem_wrreq_i = 1'b0;
    checks++;
    if (bus.cmd_valid_o !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL oor_noload got v=%b st=%0d exp v=0 st=0", bus.cmd_valid_o, dbg_state);
    end
  endtask

  task automatic test_page_hint();
    logic [2:0]  exp_hit;
    logic [31:0] adrs [3];
`ifdef DDR3_ARB_PAGE_HINT_EN
    exp_hit = 3'b010;
`else
    exp_hit = 3'b000;
`endif
    adrs[0] = 32'h0002_A000; adrs[1] = 32'h0002_A004; adrs[2] = 32'h0003_2000;
    bus.mem_rdreq_i = 1'b1; bus.mem_rdlst_i = 1'b1; bus.mem_rdtid_i = 4'd4;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rdadr_i = adrs[i];
      tick();
      checks++;
      if (bus.cmd_hit_o !== exp_hit[i] || bus.cmd_bank_o !== 3'd2) begin
        errors++; $display("FAIL hint%0d got hit=%b bank=%0d exp hit=%b bank=2", i,
          bus.cmd_hit_o, bus.cmd_bank_o, exp_hit[i]);
      end
    end
    bus.mem_rdreq_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_lock();
    bus.cmd_ready_i = 1'b0;
    bus.mem_rdreq_i = 1'b1; bus.mem_rdlst_i = 1'b0; bus.mem_rdadr_i = 32'h0000_0200; bus.mem_rdtid_i = 4'd6;
    #3;
    checks++;
    if (bus.mem_rdack_o !== 1'b1) begin
      errors++; $display("FAIL rlock_ack got %b exp 1", bus.mem_rdack_o);
    end
    tick();
    bus.mem_rdreq_i = 1'b0;
    checks++;
    if (dbg_state !== ST_LOCK_RD || bus.cmd_valid_o !== 1'b1) begin
      errors++; $display("FAIL rlock_state got st=%0d v=%b exp st=2 v=1", dbg_state, bus.cmd_valid_o);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.cmd_valid_o !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rlock_async got v=%b st=%0d exp v=0 st=0", bus.cmd_valid_o, dbg_state);
    end
    #1 reset = 1'b0;
    bus.cmd_ready_i = 1'b1;
    tick();
    checks++;
    if (bus.cmd_valid_o !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rlock_after got v=%b st=%0d exp v=0 st=0", bus.cmd_valid_o, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_read_priority();
    test_starvation();
    test_write_seq();
    test_stall();
    test_out_of_range();
    test_page_hint();
    test_reset_in_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
